// File: rtl/ins_mem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
interface ins_mem_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, wr_en, wr_addr, wr_data
  );

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/ins_mem_loader.sv
// Program loader: assembles big-endian words from a byte stream and writes them
// to consecutive word-aligned instruction-memory addresses, stalling the CPU meanwhile.
module ins_mem_loader #(
  parameter int DEPTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  ins_mem_loader_if.slave  bus,
  output logic             cpu_hold,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] word_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0]       state_q,    state_d;
  logic [31:0]      word_q,     word_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0] ptr_q,      ptr_d;
  logic             last_q,     last_d;
  logic [31:0]      wr_addr_q,  wr_addr_d;
  logic [31:0]      wr_data_q,  wr_data_d;

  logic        accept;
  logic [31:0] next_word;

  assign accept    = (state_q == S_LOAD) && bus.in_valid;
  assign next_word = {word_q[23:0], bus.in_data};

  // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    ptr_d      = ptr_q;
    last_d     = last_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LOAD;
          word_d     = '0;
          byte_cnt_d = '0;
          ptr_d      = '0;
          last_d     = 1'b0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          word_d     = next_word;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // A full memory rejects the word instead of wrapping onto address 0.
            if (ptr_q == CNT_W'(DEPTH)) begin
              state_d = S_ERR;
            end else begin
              state_d   = S_WRITE;
              last_d    = bus.in_last;
              wr_addr_d = {{(30-CNT_W){1'b0}}, ptr_q, 2'b00};
              wr_data_d = next_word;
            end
          end else if (bus.in_last) begin
            state_d = S_ERR;
          end
        end
      end
      S_WRITE: begin
        ptr_d   = ptr_q + CNT_W'(1);
        state_d = last_q ? S_DONE : S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      word_q     <= '0;
      byte_cnt_q <= '0;
      ptr_q      <= '0;
      last_q     <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
      ptr_q      <= ptr_d;
      last_q     <= last_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign bus.in_ready = (state_q == S_LOAD);
  assign bus.wr_en    = (state_q == S_WRITE);
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign cpu_hold     = (state_q == S_LOAD) || (state_q == S_WRITE) || (state_q == S_ERR);
  assign done         = (state_q == S_DONE);
  assign error        = (state_q == S_ERR);
  assign word_count   = ptr_q;

endmodule

// File: tb/tb_ins_mem_loader.sv
// Directed self-checking bench for the instruction-memory program loader.
module tb_ins_mem_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       cpu_hold;
  logic       done;
  logic       error;
  logic [6:0] word_count;

  ins_mem_loader_if lif ();

  ins_mem_loader #(.DEPTH(64), .CNT_W(7)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (lif),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int hs_cnt = 0;
  int last_hs = -10;
  logic [63:0] wr_q[$];
  logic [7:0]  byte_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Observe handshakes and writes between clock edges.
  always @(negedge clk) begin
    if (lif.in_valid === 1'b1 && lif.in_ready === 1'b1) begin
      hs_cnt++;
      last_hs = cyc;
      byte_log.push_back(lif.in_data);
    end
    if (lif.wr_en === 1'b1) begin
      wr_q.push_back({lif.wr_addr, lif.wr_data});
      check("wr_latency", cyc, last_hs + 1);
      check("ready_in_write", 32'(lif.in_ready), 32'd0);
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic last, input int gap);
    lif.in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    lif.in_valid = 1'b1;
    lif.in_data  = d;
    lif.in_last  = last;
    for (int w = 0; ; w++) begin
      @(negedge clk);
      if (lif.in_ready) break;
      if (w == 50) begin
        check("ready_timeout", 32'(lif.in_ready), 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    lif.in_valid = 1'b0;
    lif.in_last  = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic last);
    send_byte(w[31:24], 1'b0, 0);
    send_byte(w[23:16], 1'b0, 0);
    send_byte(w[15:8],  1'b0, 0);
    send_byte(w[7:0],   last, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic expect_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
    logic [63:0] e;
    check({tag, "_present"}, 32'(wr_q.size() > 0), 32'd1);
    if (wr_q.size() > 0) begin
      e = wr_q.pop_front();
      check({tag, "_addr"}, e[63:32], addr);
      check({tag, "_data"}, e[31:0], data);
    end
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic h,
                              input logic [6:0] wc);
    check({tag, "_done"},  32'(done),       32'(d));
    check({tag, "_error"}, 32'(error),      32'(e));
    check({tag, "_hold"},  32'(cpu_hold),   32'(h));
    check({tag, "_count"}, 32'(word_count), 32'(wc));
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0]  prog [8];
    logic [31:0] w;
    int          hs0;

    reset = 1'b1;
    start = 1'b0;
    lif.in_valid = 1'b0;
    lif.in_data  = 8'h00;
    lif.in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_wr_en",   32'(lif.wr_en),    32'd0);
    check("rst_wr_addr", lif.wr_addr,       32'd0);
    check("rst_wr_data", lif.wr_data,       32'd0);
    check("rst_ready",   32'(lif.in_ready), 32'd0);
    check_status("rst", 1'b0, 1'b0, 1'b0, 7'd0);
    to_drive();

    // Basic two-word load
    prog = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    pulse_start();
    @(negedge clk);
    check("load_ready", 32'(lif.in_ready), 32'd1);
    check("load_hold",  32'(cpu_hold),     32'd1);
    to_drive();
    for (int i = 0; i < 8; i++) send_byte(prog[i], i == 7, 0);
    repeat (2) @(negedge clk);
    expect_write("basic_w0", 32'd0, 32'h20080005);
    expect_write("basic_w1", 32'd4, 32'h01095020);
    check_status("basic", 1'b1, 1'b0, 1'b0, 7'd2);
    check("basic_ready", 32'(lif.in_ready), 32'd0);
    check("basic_extra", 32'(wr_q.size()), 32'd0);
    to_drive();

    // Handshake with bubbles; next byte is held valid through each WRITE cycle
    pulse_start();
    @(negedge clk);
    check("hs_count_clr", 32'(word_count), 32'd0);
    check("hs_done_clr",  32'(done),       32'd0);
    to_drive();
    hs0 = hs_cnt;
    byte_log.delete();
    for (int i = 0; i < 12; i++) send_byte(8'(8'h30 + i), i == 11, int'($urandom_range(0, 2)));
    repeat (2) @(negedge clk);
    check("hs_bytes", 32'(hs_cnt - hs0), 32'd12);
    for (int i = 0; i < 12; i++) begin
      if (i < byte_log.size()) check("hs_order", 32'(byte_log[i]), 32'(8'h30 + i));
    end
    expect_write("hs_w0", 32'd0, 32'h30313233);
    expect_write("hs_w1", 32'd4, 32'h34353637);
    expect_write("hs_w2", 32'd8, 32'h38393a3b);
    check_status("hs", 1'b1, 1'b0, 1'b0, 7'd3);
    to_drive();

    // Partial word: in_last on the 2nd byte of the second word
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(8'(8'hA0 + i), i == 5, 0);
    repeat (2) @(negedge clk);
    expect_write("part_w0", 32'd0, 32'hA0A1A2A3);
    check("part_extra", 32'(wr_q.size()), 32'd0);
    check_status("part", 1'b0, 1'b1, 1'b1, 7'd1);
    check("part_ready", 32'(lif.in_ready), 32'd0);
    to_drive();

    // Overflow: 65 words into a 64-word memory, started from ERR
    pulse_start();
    for (int i = 0; i < 65; i++) begin
      w = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
      send_word(w, 1'b0);
    end
    repeat (2) @(negedge clk);
    check("ovf_nwrites", 32'(wr_q.size()), 32'd64);
    for (int i = 0; i < 64; i++) begin
      w = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
      expect_write("ovf", 32'(4*i), w);
    end
    check_status("ovf", 1'b0, 1'b1, 1'b1, 7'd64);
    to_drive();

    // Reset in the middle of a word, then a fresh single-word load
    pulse_start();
    send_byte(8'h5A, 1'b0, 0);
    send_byte(8'hA5, 1'b0, 0);
    reset = 1'b1;
    to_drive();
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_wr_en",   32'(lif.wr_en),    32'd0);
    check("mid_rst_wr_addr", lif.wr_addr,       32'd0);
    check("mid_rst_wr_data", lif.wr_data,       32'd0);
    check("mid_rst_ready",   32'(lif.in_ready), 32'd0);
    check_status("mid_rst", 1'b0, 1'b0, 1'b0, 7'd0);
    to_drive();
    pulse_start();
    send_word(32'hAABBCCDD, 1'b1);
    repeat (2) @(negedge clk);
    expect_write("after_rst", 32'd0, 32'hAABBCCDD);
    check_status("after_rst", 1'b1, 1'b0, 1'b0, 7'd1);
    to_drive();

    // start during LOAD is ignored; start from DONE restarts at address 0
    pulse_start();
    send_byte(8'h11, 1'b0, 0);
    send_byte(8'h22, 1'b0, 0);
    pulse_start();
    send_byte(8'h33, 1'b0, 0);
    send_byte(8'h44, 1'b0, 0);
    send_word(32'h55667788, 1'b1);
    repeat (2) @(negedge clk);
    expect_write("ign_w0", 32'd0, 32'h11223344);
    expect_write("ign_w1", 32'd4, 32'h55667788);
    check_status("ign", 1'b1, 1'b0, 1'b0, 7'd2);
    to_drive();
    pulse_start();
    @(negedge clk);
    check_status("restart_entry", 1'b0, 1'b0, 1'b1, 7'd0);
    to_drive();
    send_word(32'hC0C1C2C3, 1'b1);
    repeat (2) @(negedge clk);
    expect_write("restart", 32'd0, 32'hC0C1C2C3);
    check_status("restart", 1'b1, 1'b0, 1'b0, 7'd1);
    check("final_extra", 32'(wr_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ins_mem_loader.md
Name: ins_mem_loader

Overview:
- Program loader that fills the instruction memory at run time; it is the write-side counterpart of the CPU's read-only instruction fetch port.
- Accepts a byte stream through a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Issues one-cycle word writes at incrementing word-aligned byte addresses.
- Holds the CPU in reset-like stall (cpu_hold) while loading and flags completion or error.

Parameters:
- DEPTH, 64, instruction memory depth in 32-bit words; also the maximum number of words per load.
- CNT_W, 7, width of word_count; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  pulse that begins a load session.
- in_valid  input  1  byte source has data.
- in_ready  output  1  loader can accept a byte this cycle.
- in_data  input  8  stream byte; the first byte of each word is the MSB.
- in_last  input  1  qualifies in_data as the final byte of the program.
- wr_en  output  1  one-cycle write strobe to instruction memory.
- wr_addr  output  32  byte address, always a multiple of 4.
- wr_data  output  32  assembled instruction word.
- cpu_hold  output  1  high while a load is in progress or has failed; CPU must not fetch.
- done  output  1  load completed successfully.
- error  output  1  load aborted (partial word or overflow).
- word_count  output  CNT_W  number of words written in the current session.

Behaviour:
- Reset: state IDLE; all outputs 0, including wr_addr, wr_data and word_count. The byte counter, word pointer and shift register are cleared.
- Reset mid-load: the loader returns to IDLE and discards the partial word. Words already written stay in memory.
- States: IDLE, LOAD, WRITE, DONE, ERR.
- IDLE:
  - in_ready=0, cpu_hold=0.
  - start=1 -> LOAD; clear byte_cnt, ptr, word_count, done and error.
- LOAD:
  - in_ready=1, cpu_hold=1.
  - A byte is accepted only when in_valid && in_ready.
  - Each accepted byte shifts in: word <= {word[23:0], in_data}; byte_cnt increments modulo 4.
  - 4th byte accepted with ptr < DEPTH -> WRITE. The in_last value of that byte is latched.
  - 4th byte accepted with ptr == DEPTH -> ERR; no write.
  - in_last on the 1st–3rd byte of a word -> ERR; no write, partial word dropped.
- WRITE (exactly 1 cycle):
  - wr_en=1, wr_addr=ptr*4, wr_data=assembled word, in_ready=0. A byte presented in this cycle is not consumed.
  - Next cycle: ptr and word_count increment; go to DONE if latched last, else LOAD.
  - Latency: 4th-byte handshake at cycle t -> wr_en high at cycle t+1.
- DONE:
  - done=1, cpu_hold=0, in_ready=0.
  - start=1 -> LOAD (new session; memory is overwritten from address 0).
- ERR:
  - error=1, cpu_hold=1, in_ready=0.
  - Only start or reset leaves ERR. start -> LOAD as from IDLE.
- start asserted in LOAD or WRITE is ignored.
- wr_addr and wr_data hold their last written values when wr_en=0. wr_en is never high outside WRITE.
- done and error are never both 1. Both clear on the cycle LOAD is entered.

Test Plan:
- Basic load: reset, start, stream 20 08 00 05 01 09 50 20 with in_last on the 8th byte -> wr_en pulses with (addr 0, 32'h20080005) and (addr 4, 32'h01095020); then done=1, word_count=2, cpu_hold=0.
- Handshake: random in_valid bubbles, plus a byte held valid during the WRITE cycle -> in_ready=0 in WRITE; the byte is consumed the following cycle; no byte is lost or duplicated; wr_en rises exactly one cycle after the 4th handshake.
- Partial word: 6 bytes with in_last on the 6th -> exactly one write (addr 0); error=1, done=0, cpu_hold=1, word_count=1.
- Overflow at DEPTH=64: 65 words, no in_last -> 64 writes at addr 0..252; the 65th word's 4th byte -> error=1, no write at 256, word_count=64.
- Reset mid-load: reset after 2 bytes -> all outputs 0, IDLE. Then start and bytes AA BB CC DD with in_last -> write (addr 0, 32'hAABBCCDD), done=1.
- Restart: start pulsed during LOAD is ignored. From DONE, start and 4 bytes with in_last -> write at addr 0; word_count restarts at 1.
